bp_tlb_arbiter: RTL and testbench

BP_TLB_ARBITER -- requirements
Module: bp_tlb_arbiter

---
 rtl/bp_tlb_arbiter.sv | 140 ++++++++++++++
 tb/tb_bp_tlb_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bp_tlb_arbiter.sv
// Shares one TLB port among the fetch and load/store lookups, page-walker
// fills and sfence flushes. Tracks one outstanding miss toward the walker.
module bp_tlb_arbiter #(
  parameter int vtag_width_p  = 27,
  parameter int entry_width_p = 34
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic [1:0]                req_v_i,
  input  logic [2*vtag_width_p-1:0] req_vtag_i,
  output logic [1:0]                req_ready_o,

  output logic                      resp_v_o,
  output logic                      resp_id_o,
  output logic                      resp_hit_o,
  output logic [entry_width_p-1:0]  resp_entry_o,

  output logic                      miss_v_o,
  output logic [vtag_width_p-1:0]   miss_vtag_o,

  input  logic                      fill_v_i,
  input  logic [vtag_width_p-1:0]   fill_vtag_i,
  input  logic [entry_width_p-1:0]  fill_entry_i,
  output logic                      fill_ready_o,

  input  logic                      sfence_v_i,
  output logic                      sfence_ready_o,

  output logic                      tlb_v_o,
  output logic                      tlb_w_o,
  output logic                      tlb_flush_o,
  output logic [vtag_width_p-1:0]   tlb_vtag_o,
  output logic [entry_width_p-1:0]  tlb_entry_o,
  input  logic                      tlb_v_i,
  input  logic [entry_width_p-1:0]  tlb_entry_i
);

  typedef enum logic {IDLE, MISS} state_e;

  state_e                    state_q;
  logic                      miss_v_q;
  logic                      miss_id_q;
  logic [vtag_width_p-1:0]   miss_vtag_q;
  logic                      reset_q;
  logic                      last_q;
  logic                      pend_v_q;
  logic                      pend_id_q;
  logic [vtag_width_p-1:0]   pend_vtag_q;

  logic                      blk;
  logic                      flush_acc;
  logic                      fill_acc;
  logic [1:0]                elig;
  logic [1:0]                grant;
  logic                      gnt_id;
  logic [vtag_width_p-1:0]   gnt_vtag;

  // Arbitration: flush beats fill beats lookup; lookups round-robin.
  // Everything is held off during reset and the cycle right after it.
  always_comb begin
    blk       = reset_i | reset_q;
    flush_acc = ~blk & sfence_v_i & ~miss_v_q;
    fill_acc  = ~blk & fill_v_i & ~flush_acc;
    elig[0]   = ~blk & req_v_i[0] & ~(miss_v_q & ~miss_id_q);
    elig[1]   = ~blk & req_v_i[1] & ~(miss_v_q &  miss_id_q);
    grant     = '0;
    gnt_id    = 1'b0;
    if (~flush_acc & ~fill_acc) begin
      gnt_id        = (&elig) ? ~last_q : elig[1];
      grant[gnt_id] = |elig;
    end
    gnt_vtag = gnt_id ? req_vtag_i[2*vtag_width_p-1:vtag_width_p]
                      : req_vtag_i[vtag_width_p-1:0];

    req_ready_o    = grant;
    sfence_ready_o = flush_acc;
    fill_ready_o   = fill_acc;
    tlb_flush_o    = flush_acc;
    tlb_w_o        = fill_acc;
    tlb_v_o        = fill_acc | (|grant);
    tlb_vtag_o     = fill_acc ? fill_vtag_i : gnt_vtag;
    tlb_entry_o    = fill_entry_i;

    resp_v_o       = pend_v_q & ~blk;
    resp_id_o      = pend_id_q;
    resp_hit_o     = tlb_v_i;
    resp_entry_o   = tlb_entry_i;
    miss_v_o       = miss_v_q & ~blk;
    miss_vtag_o    = miss_vtag_q;
  end

  // Delayed reset used to hold the block quiet for one extra cycle.
  always_ff @(posedge clk_i) begin
    reset_q <= reset_i;
  end

  // Read pipeline and round-robin pointer: the TLB answers one cycle later.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_v_q    <= 1'b0;
      pend_id_q   <= 1'b0;
      pend_vtag_q <= '0;
      last_q      <= 1'b1;
    end else begin
      pend_v_q    <= |grant;
      pend_id_q   <= gnt_id;
      pend_vtag_q <= gnt_vtag;
      if (|grant) last_q <= gnt_id;
    end
  end

  // Miss tracking: first miss seen while idle is owned until its fill lands.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      miss_v_q    <= 1'b0;
      miss_id_q   <= 1'b0;
      miss_vtag_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (pend_v_q & ~tlb_v_i) begin
          state_q     <= MISS;
          miss_v_q    <= 1'b1;
          miss_id_q   <= pend_id_q;
          miss_vtag_q <= pend_vtag_q;
        end
        MISS: if (fill_acc && fill_vtag_i == miss_vtag_q) begin
          state_q  <= IDLE;
          miss_v_q <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          miss_v_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_tlb_arbiter.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared each cycle against a rule-level reference model.
module tb_bp_tlb_arbiter;
  localparam int VW = 27;
  localparam int EW = 34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_i = 1'b1;
  logic [1:0]      req_v_i = '0;
  logic [2*VW-1:0] req_vtag_i = '0;
  logic [1:0]      req_ready_o;
  logic            resp_v_o, resp_id_o, resp_hit_o;
  logic [EW-1:0]   resp_entry_o;
  logic            miss_v_o;
  logic [VW-1:0]   miss_vtag_o;
  logic            fill_v_i = 1'b0;
  logic [VW-1:0]   fill_vtag_i = '0;
  logic [EW-1:0]   fill_entry_i = '0;
  logic            fill_ready_o;
  logic            sfence_v_i = 1'b0;
  logic            sfence_ready_o;
  logic            tlb_v_o, tlb_w_o, tlb_flush_o;
  logic [VW-1:0]   tlb_vtag_o;
  logic [EW-1:0]   tlb_entry_o;
  logic            tlb_v_i = 1'b0;
  logic [EW-1:0]   tlb_entry_i = '0;

  bp_tlb_arbiter #(.vtag_width_p(VW), .entry_width_p(EW)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_vtag_i(req_vtag_i), .req_ready_o(req_ready_o),
    .resp_v_o(resp_v_o), .resp_id_o(resp_id_o), .resp_hit_o(resp_hit_o),
    .resp_entry_o(resp_entry_o),
    .miss_v_o(miss_v_o), .miss_vtag_o(miss_vtag_o),
    .fill_v_i(fill_v_i), .fill_vtag_i(fill_vtag_i), .fill_entry_i(fill_entry_i),
    .fill_ready_o(fill_ready_o),
    .sfence_v_i(sfence_v_i), .sfence_ready_o(sfence_ready_o),
    .tlb_v_o(tlb_v_o), .tlb_w_o(tlb_w_o), .tlb_flush_o(tlb_flush_o),
    .tlb_vtag_o(tlb_vtag_o), .tlb_entry_o(tlb_entry_o),
    .tlb_v_i(tlb_v_i), .tlb_entry_i(tlb_entry_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stand-in TLB driven by whatever the DUT actually issued.
  logic [EW-1:0] tlb_mem [logic [VW-1:0]];
  logic          op_flush = 1'b0, op_w = 1'b0, op_r = 1'b0;
  logic [VW-1:0] op_vtag  = '0;
  logic [EW-1:0] op_entry = '0;

  always @(posedge clk) begin
    if (op_flush) tlb_mem.delete();
    else if (op_w) tlb_mem[op_vtag] = op_entry;
    if (op_r && tlb_mem.exists(op_vtag)) begin
      tlb_v_i     <= 1'b1;
      tlb_entry_i <= tlb_mem[op_vtag];
    end else begin
      tlb_v_i     <= op_r ? 1'b0 : 1'($urandom);
      tlb_entry_i <= EW'({$urandom, $urandom});
    end
  end

  // Reference model state.
  logic [EW-1:0] ref_tlb [logic [VW-1:0]];
  bit            m_rst_prev = 1'b1;
  bit            m_last = 1'b1;
  bit            m_miss = 1'b0;
  bit            m_miss_id = 1'b0;
  logic [VW-1:0] m_miss_vtag = '0;
  bit            m_rv = 1'b0, m_rid = 1'b0, m_rhit = 1'b0;
  logic [VW-1:0] m_rvtag = '0;
  logic [EW-1:0] m_rent = '0;

  task automatic run_cycle(input bit rst, input int unsigned rv,
                           input int unsigned v0, input int unsigned v1,
                           input bit fv, input int unsigned fvt,
                           input longint unsigned fe, input bit sf);
    bit blk, e_sf, e_fill, el0, el1;
    int gnt;
    logic [VW-1:0] gv;
    @(posedge clk);
    #1;
    reset_i      = rst;
    req_v_i      = 2'(rv);
    req_vtag_i   = {VW'(v1), VW'(v0)};
    fill_v_i     = fv;
    fill_vtag_i  = VW'(fvt);
    fill_entry_i = EW'(fe);
    sfence_v_i   = sf;
    @(negedge clk);

    blk    = rst || m_rst_prev;
    e_sf   = !blk && sf && !m_miss;
    e_fill = !blk && fv && !e_sf;
    el0    = !blk && rv[0] && !(m_miss && !m_miss_id);
    el1    = !blk && rv[1] && !(m_miss && m_miss_id);
    gnt    = -1;
    if (!e_sf && !e_fill) begin
      if (el0 && el1) gnt = m_last ? 0 : 1;
      else if (el0)   gnt = 0;
      else if (el1)   gnt = 1;
    end
    gv = (gnt == 1) ? VW'(v1) : VW'(v0);

    check("sfence_ready", 64'(sfence_ready_o), 64'(e_sf));
    check("fill_ready",   64'(fill_ready_o),   64'(e_fill));
    check("req_ready",    64'(req_ready_o),    (gnt < 0) ? 64'd0 : (64'd1 << gnt));
    check("tlb_v",        64'(tlb_v_o),        64'(e_fill || gnt >= 0));
    check("tlb_w",        64'(tlb_w_o),        64'(e_fill));
    check("tlb_flush",    64'(tlb_flush_o),    64'(e_sf));
    if (e_fill) begin
      check("tlb_vtag_fill",  64'(tlb_vtag_o),  64'(VW'(fvt)));
      check("tlb_entry_fill", 64'(tlb_entry_o), 64'(EW'(fe)));
    end else if (gnt >= 0) begin
      check("tlb_vtag_read",  64'(tlb_vtag_o),  64'(gv));
    end
    check("resp_v", 64'(resp_v_o), 64'(m_rv && !blk));
    if (m_rv && !blk) begin
      check("resp_id",  64'(resp_id_o),  64'(m_rid));
      check("resp_hit", 64'(resp_hit_o), 64'(m_rhit));
      if (m_rhit) check("resp_entry", 64'(resp_entry_o), 64'(m_rent));
    end
    check("miss_v", 64'(miss_v_o), 64'(m_miss && !blk));
    if (m_miss && !blk) check("miss_vtag", 64'(miss_vtag_o), 64'(m_miss_vtag));

    op_flush = tlb_flush_o;
    op_w     = tlb_v_o & tlb_w_o;
    op_r     = tlb_v_o & ~tlb_w_o;
    op_vtag  = tlb_vtag_o;
    op_entry = tlb_entry_o;

    if (rst) begin
      m_last = 1'b1;
      m_miss = 1'b0;
      m_rv   = 1'b0;
    end else begin
      if (m_miss) begin
        if (e_fill && VW'(fvt) == m_miss_vtag) m_miss = 1'b0;
      end else if (m_rv && !m_rhit) begin
        m_miss      = 1'b1;
        m_miss_id   = m_rid;
        m_miss_vtag = m_rvtag;
      end
      m_rv = (gnt >= 0);
      if (gnt >= 0) begin
        m_rid   = (gnt == 1);
        m_rvtag = gv;
        m_rhit  = ref_tlb.exists(gv);
        m_rent  = m_rhit ? ref_tlb[gv] : '0;
        m_last  = (gnt == 1);
      end
      if (e_sf)   ref_tlb.delete();
      if (e_fill) ref_tlb[VW'(fvt)] = EW'(fe);
    end
    m_rst_prev = rst;
  endtask

  task automatic idle();
    run_cycle(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int unsigned pv0, pv1, fvt;
    // Reset, then the quiet cycle after it.
    run_cycle(1'b1, 3, 'h10, 'h10, 1'b1, 'h10, 64'h1, 1'b1);
    run_cycle(1'b1, 3, 'h10, 'h10, 1'b1, 'h10, 64'h1, 1'b1);
    run_cycle(1'b0, 3, 'h10, 'h10, 1'b1, 'h10, 64'h1, 1'b1);
    idle();
    // Preload, then both requesters hitting for four cycles.
    run_cycle(1'b0, 0, 0, 0, 1'b1, 'h10, 64'h2_0000_0AAA, 1'b0);
    repeat (4) run_cycle(1'b0, 3, 'h10, 'h10, 1'b0, 0, 0, 1'b0);
    idle();
    // Requester 0 misses on 0x12345; only requester 1 proceeds afterwards.
    run_cycle(1'b0, 1, 'h12345, 0, 1'b0, 0, 0, 1'b0);
    idle();
    idle();
    repeat (3) run_cycle(1'b0, 3, 'h12345, 'h10, 1'b0, 0, 0, 1'b0);
    // Flush held off while the miss is outstanding.
    repeat (2) run_cycle(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b1);
    run_cycle(1'b0, 1, 'h12345, 0, 1'b1, 'h12345, 64'h3_1234_5678, 1'b1);
    run_cycle(1'b0, 1, 'h12345, 0, 1'b0, 0, 0, 1'b0);
    idle();
    run_cycle(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b1);
    run_cycle(1'b0, 1, 'h12345, 0, 1'b0, 0, 0, 1'b0);
    idle();
    idle();
    run_cycle(1'b0, 0, 0, 0, 1'b1, 'h12345, 64'h1_0F0F_0F0F, 1'b0);
    idle();
    // Flush, fill and both lookups together.
    run_cycle(1'b0, 3, 'h10, 'h20, 1'b1, 'h20, 64'h2_2222_2222, 1'b1);
    repeat (2) run_cycle(1'b0, 3, 'h10, 'h20, 1'b1, 'h20, 64'h2_2222_2222, 1'b0);
    idle();
    idle();
    // Reset right after a grant drops the in-flight response.
    run_cycle(1'b0, 1, 'h20, 0, 1'b0, 0, 0, 1'b0);
    run_cycle(1'b1, 0, 0, 0, 1'b0, 0, 0, 1'b0);
    idle();
    idle();
    // Random traffic over a small vtag pool.
    for (int i = 0; i < 800; i++) begin
      pv0 = 'h100 + $urandom_range(0, 7);
      pv1 = 'h100 + $urandom_range(0, 7);
      fvt = (m_miss && $urandom_range(0, 1) == 1) ? int'(m_miss_vtag)
                                                   : 'h100 + $urandom_range(0, 7);
      run_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3), pv0, pv1,
                $urandom_range(0, 3) == 0, fvt,
                {32'($urandom), 32'($urandom)}, $urandom_range(0, 15) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
